// File: rtl/serdes_pkg.sv
// Shared definitions for the SERDES bring-up controllers: FSM state encoding,
// default training word and a small sizing helper.
package serdes_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRst    = 3'd1,
    StSettle = 3'd2,
    StCheck  = 3'd3,
    StSlip   = 3'd4,
    StLocked = 3'd5,
    StErr    = 3'd6
  } serdes_state_e;

  localparam logic [7:0] TrainPatDefault = 8'hE4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serdes_rx_align_ctrl.sv
// RX SERDES bring-up and word-alignment controller: waits for PLL lock, resets the
// SERDES, then bitslips until the training word is seen MATCH_CNT times in a row.
module serdes_rx_align_ctrl
  import serdes_pkg::*;
#(
  parameter int unsigned       WORD_W        = 8,
  parameter logic [WORD_W-1:0] TRAIN_PAT     = WORD_W'(TrainPatDefault),
  parameter int unsigned       RST_CYCLES    = 32,
  parameter int unsigned       SETTLE_CYCLES = 16,
  parameter int unsigned       MATCH_CNT     = 16,
  parameter int unsigned       MAX_SLIPS     = 8
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_pll_lock,
  input  logic              I_restart,
  input  logic [WORD_W-1:0] I_rx_data,
  output logic              O_serdes_rst,
  output logic              O_bitslip,
  output logic              O_align_done,
  output logic              O_align_err,
  output logic [3:0]        O_slip_cnt
);

  localparam int unsigned CntMax = max3(RST_CYCLES, SETTLE_CYCLES, MATCH_CNT);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] RstLast    = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] MatchLast  = CntW'(MATCH_CNT - 1);
  localparam logic [3:0]      SlipLimit  = 4'(MAX_SLIPS);

  serdes_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] match_q, match_d;
  logic [3:0]      slip_q, slip_d;
  logic            serdes_rst_q, serdes_rst_d;
  logic            bitslip_q, bitslip_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    slip_d  = slip_q;

    if (state_q != StIdle && !I_pll_lock) begin
      state_d = StIdle;
      cnt_d   = '0;
      match_d = '0;
      slip_d  = '0;
    end else if (state_q != StIdle && I_restart) begin
      state_d = StRst;
      cnt_d   = '0;
      match_d = '0;
      slip_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d   = '0;
          match_d = '0;
          slip_d  = '0;
          if (I_pll_lock) state_d = StRst;
        end
        StRst: begin
          if (cnt_q == RstLast) begin
            state_d = StSettle;
            cnt_d   = '0;
            match_d = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            state_d = StCheck;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StCheck: begin
          if (I_rx_data == TRAIN_PAT) begin
            if (match_q == MatchLast) begin
              state_d = StLocked;
            end else begin
              match_d = match_q + CntW'(1);
            end
          end else begin
            match_d = '0;
            if (slip_q < SlipLimit) begin
              state_d = StSlip;
              slip_d  = (slip_q == 4'hF) ? slip_q : slip_q + 4'd1;
            end else begin
              state_d = StErr;
            end
          end
        end
        StSlip: begin
          state_d = StSettle;
          cnt_d   = '0;
          match_d = '0;
        end
        StLocked, StErr: ;
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          match_d = '0;
          slip_d  = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with state_q.
    serdes_rst_d = (state_d == StRst);
    bitslip_d    = (state_d == StSlip);
    done_d       = (state_d == StLocked);
    err_d        = (state_d == StErr);
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      match_q      <= '0;
      slip_q       <= '0;
      serdes_rst_q <= 1'b0;
      bitslip_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      match_q      <= match_d;
      slip_q       <= slip_d;
      serdes_rst_q <= serdes_rst_d;
      bitslip_q    <= bitslip_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign O_serdes_rst = serdes_rst_q;
  assign O_bitslip    = bitslip_q;
  assign O_align_done = done_q;
  assign O_align_err  = err_q;
  assign O_slip_cnt   = slip_q;

endmodule
